// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: steps one shared convolution unit across every filter window of an HxW map.
// Build option CONV_SCHED_RELU_EN: clamp captured results with the sign bit set to zero.
module conv_window_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 1,
    parameter int F          = 3,
    parameter int H          = 8,
    parameter int W          = 8,
    parameter int STRIDE     = 1,
    localparam int OH        = (H - F) / STRIDE + 1,
    localparam int OW        = (W - F) / STRIDE + 1,
    localparam int RW        = (H > 1) ? $clog2(H) : 1,
    localparam int CWW       = (W > 1) ? $clog2(W) : 1,
    localparam int ORW       = (OH > 1) ? $clog2(OH) : 1,
    localparam int OCW       = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         win_row,
    output logic [CWW-1:0]        win_col,
    output logic                  unit_reset,
    input  logic [DATA_WIDTH-1:0] unit_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ORW-1:0]        out_row,
    output logic [OCW-1:0]        out_col
);

    localparam int ACC  = D * F * F + 2;
    localparam int CNTW = $clog2(ACC);

    localparam logic [CNTW-1:0] CNT_LAST     = CNTW'(ACC - 1);
    localparam logic [RW-1:0]   ROW_STEP     = RW'(STRIDE);
    localparam logic [CWW-1:0]  COL_STEP     = CWW'(STRIDE);
    localparam logic [ORW-1:0]  OUT_ROW_LAST = ORW'(OH - 1);
    localparam logic [OCW-1:0]  OUT_COL_LAST = OCW'(OW - 1);

    generate
        if (H < F || W < F || STRIDE < 1) begin : g_illegal_geometry
            $error("conv_window_scheduler: filter larger than map or STRIDE < 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_OUT,
        S_FIN
    } state_t;

    state_t                  state_reg;
    logic [CNTW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0]   captured;

`ifdef CONV_SCHED_RELU_EN
    // Sign-bit test also catches -0.0.
    assign captured = unit_result[DATA_WIDTH-1] ? '0 : unit_result;
`else
    assign captured = unit_result;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            unit_reset <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    unit_reset <= 1'b1;
                    if (start) begin
                        state_reg <= S_CLEAR;
                        busy      <= 1'b1;
                        win_row   <= '0;
                        win_col   <= '0;
                        out_row   <= '0;
                        out_col   <= '0;
                    end
                end
                S_CLEAR: begin
                    state_reg  <= S_RUN;
                    unit_reset <= 1'b0;
                    cnt_reg    <= '0;
                end
                S_RUN: begin
                    if (cnt_reg == CNT_LAST) begin
                        out_data   <= captured;
                        out_valid  <= 1'b1;
                        unit_reset <= 1'b1;
                        state_reg  <= S_OUT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_OUT: begin
                    // Window coordinates only move on the handshake, so a stall freezes the slicer.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_col == OUT_COL_LAST) begin
                            out_col <= '0;
                            win_col <= '0;
                            if (out_row == OUT_ROW_LAST) begin
                                out_row   <= '0;
                                win_row   <= '0;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= S_FIN;
                            end else begin
                                out_row   <= out_row + 1'b1;
                                win_row   <= win_row + ROW_STEP;
                                state_reg <= S_CLEAR;
                            end
                        end else begin
                            out_col   <= out_col + 1'b1;
                            win_col   <= win_col + COL_STEP;
                            state_reg <= S_CLEAR;
                        end
                    end
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: a 4x4/F3/S1 instance and an 8x8/F3/S2 instance.
module tb_conv_window_scheduler;

    logic        clk;
    logic        reset;

    logic        start_a, out_ready_a;
    logic [31:0] unit_result_a;
    logic        busy_a, done_a, unit_reset_a, out_valid_a;
    logic [1:0]  win_row_a, win_col_a;
    logic [31:0] out_data_a;
    logic [0:0]  out_row_a, out_col_a;

    logic        start_b, out_ready_b;
    logic [31:0] unit_result_b;
    logic        busy_b, done_b, unit_reset_b, out_valid_b;
    logic [2:0]  win_row_b, win_col_b;
    logic [31:0] out_data_b;
    logic [1:0]  out_row_b, out_col_b;

    int tests_run;
    int tests_failed;

    conv_window_scheduler #(
        .DATA_WIDTH(32), .D(1), .F(3), .H(4), .W(4), .STRIDE(1)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .win_row(win_row_a), .win_col(win_col_a), .unit_reset(unit_reset_a),
        .unit_result(unit_result_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_row(out_row_a), .out_col(out_col_a)
    );

    conv_window_scheduler #(
        .DATA_WIDTH(32), .D(1), .F(3), .H(8), .W(8), .STRIDE(2)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .win_row(win_row_b), .win_col(win_col_b), .unit_reset(unit_reset_b),
        .unit_result(unit_result_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_row(out_row_b), .out_col(out_col_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [41:0] got, exp;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            // k=0: reset held; k=1: two cycles after release with start low
            got = {busy_a, done_a, out_valid_a, unit_reset_a, out_data_a, win_row_a, win_col_a, out_row_a, out_col_a};
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL reset_state_a[%0d] got=%h exp=%h", k, got, exp);
            end
            tests_run++;
            if ({busy_b, out_valid_b, unit_reset_b, win_row_b, win_col_b} !== {1'b0, 1'b0, 1'b1, 3'd0, 3'd0}) begin
                tests_failed++;
                $display("FAIL reset_state_b[%0d] got=%b exp=%b", k,
                         {busy_b, out_valid_b, unit_reset_b, win_row_b, win_col_b}, 9'b001000000);
            end
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        int nv, low_cnt, prev_v, c;
        bit seen_done;
        logic [5:0] got, exp;
        logic       er, ec;
        unit_result_a = 32'h40400000;
        out_ready_a   = 1'b1;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        nv = 0; low_cnt = 0; prev_v = 0; seen_done = 1'b0;
        for (c = 0; c < 120 && !seen_done; c++) begin
            if (!unit_reset_a) low_cnt++;
            if (out_valid_a) begin
                er  = 1'(nv / 2);
                ec  = 1'(nv % 2);
                got = {out_row_a, out_col_a, win_row_a, win_col_a};
                exp = {er, ec, 1'b0, er, 1'b0, ec};
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL basic_coord[%0d] got=%b exp=%b", nv, got, exp);
                end
                tests_run++;
                if (out_data_a !== 32'h40400000) begin
                    tests_failed++;
                    $display("FAIL basic_data[%0d] got=%h exp=40400000", nv, out_data_a);
                end
                tests_run++;
                if (low_cnt != 11) begin
                    tests_failed++;
                    $display("FAIL basic_unit_reset_low[%0d] got=%0d exp=11", nv, low_cnt);
                end
                tests_run++;
                if ((nv == 0 && c != 12) || (nv > 0 && c - prev_v != 13)) begin
                    tests_failed++;
                    $display("FAIL basic_spacing[%0d] cycle=%0d prev=%0d exp first=12 step=13", nv, c, prev_v);
                end
                $display("[TB] basic out %0d at cycle %0d row=%0d col=%0d data=%h", nv, c, out_row_a, out_col_a, out_data_a);
                prev_v = c; low_cnt = 0; nv++;
            end
            if (done_a) begin
                seen_done = 1'b1;
                tests_run++;
                if (c != prev_v + 1 || busy_a !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL basic_done cycle=%0d busy=%b exp cycle=%0d busy=0", c, busy_a, prev_v + 1);
                end
                start_a = 1'b1;  // lands on the FIN cycle and must be ignored
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        tests_run++;
        if (!seen_done || nv != 4) begin
            tests_failed++;
            $display("FAIL basic_count outputs=%0d done=%0d exp outputs=4 done=1", nv, seen_done);
        end
        tests_run++;
        if ({busy_a, unit_reset_a} !== 2'b01) begin
            tests_failed++;
            $display("FAIL fin_start_ignored busy/unit_reset=%b exp=01", {busy_a, unit_reset_a});
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int nv, stall, c;
        bit seen_done;
        logic [5:0]  got, exp;
        logic [31:0] exp_d;
        logic        er, ec;
        out_ready_a   = 1'b1;
        unit_result_a = 32'hA5000000;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        nv = 0; stall = 0; seen_done = 1'b0;
        for (c = 0; c < 200 && !seen_done; c++) begin
            if (out_valid_a) begin
                er    = 1'(nv / 2);
                ec    = 1'(nv % 2);
                got   = {out_row_a, out_col_a, win_row_a, win_col_a};
                exp   = {er, ec, 1'b0, er, 1'b0, ec};
                exp_d = 32'hA5000000 + 32'(nv);
                tests_run++;
                if (got !== exp || out_data_a !== exp_d) begin
                    tests_failed++;
                    $display("FAIL bp_hold[%0d] stall=%0d coord=%b exp=%b data=%h exp=%h", nv, stall, got, exp, out_data_a, exp_d);
                end
                $display("[TB] bp out %0d cycle %0d stall=%0d data=%h", nv, c, stall, out_data_a);
                if (nv == 1 && stall < 5) begin
                    out_ready_a   = 1'b0;
                    unit_result_a = 32'hDEADBEEF;
                    stall++;
                end else begin
                    out_ready_a = 1'b1;
                    nv++;
                    unit_result_a = 32'hA5000000 + 32'(nv);
                end
            end
            if (done_a) seen_done = 1'b1;
            @(negedge clk);
        end
        out_ready_a = 1'b1;
        tests_run++;
        if (!seen_done || nv != 4 || stall != 5) begin
            tests_failed++;
            $display("FAIL bp_count outputs=%0d stalls=%0d done=%0d exp 4/5/1", nv, stall, seen_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stride();
        int nv, c;
        bit seen_done;
        logic [9:0] got, exp;
        logic [1:0] er, ec;
        out_ready_b   = 1'b1;
        unit_result_b = 32'h3F800000;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        nv = 0; seen_done = 1'b0;
        for (c = 0; c < 400 && !seen_done; c++) begin
            start_b = (c == 20);  // start while busy must be ignored
            if (out_valid_b) begin
                er  = 2'(nv / 3);
                ec  = 2'(nv % 3);
                got = {out_row_b, out_col_b, win_row_b, win_col_b};
                exp = {er, ec, 3'(2 * er), 3'(2 * ec)};
                tests_run++;
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL stride_coord[%0d] got=%b exp=%b", nv, got, exp);
                end
                $display("[TB] stride out %0d row=%0d col=%0d win=(%0d,%0d)", nv, out_row_b, out_col_b, win_row_b, win_col_b);
                nv++;
            end
            if (done_b) seen_done = 1'b1;
            @(negedge clk);
        end
        start_b = 1'b0;
        tests_run++;
        if (!seen_done || nv != 9) begin
            tests_failed++;
            $display("FAIL stride_count outputs=%0d done=%0d exp 9/1", nv, seen_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int nv, c;
        bit found;
        out_ready_a   = 1'b1;
        unit_result_a = 32'h12345678;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        nv = 0;
        // Outputs at cycles 12 and 25; cycle 30 is inside window 2's accumulate phase.
        for (c = 0; c < 30; c++) begin
            if (out_valid_a) nv++;
            @(negedge clk);
        end
        tests_run++;
        if (nv != 2 || unit_reset_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_position outputs=%0d unit_reset=%b exp 2/0", nv, unit_reset_a);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({busy_a, out_valid_a, unit_reset_a, out_data_a, win_row_a, win_col_a} !== {1'b0, 1'b0, 1'b1, 32'h0, 2'd0, 2'd0}) begin
            tests_failed++;
            $display("FAIL midrun_reset busy=%b valid=%b unit_reset=%b data=%h win=(%0d,%0d) exp 0/0/1/0/(0,0)",
                     busy_a, out_valid_a, unit_reset_a, out_data_a, win_row_a, win_col_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        unit_result_a = 32'h0BADF00D;
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        found = 1'b0;
        for (c = 0; c < 40 && !found; c++) begin
            if (out_valid_a) begin
                found = 1'b1;
                tests_run++;
                if (c != 12 || {out_row_a, out_col_a, win_row_a, win_col_a} !== 6'b0 || out_data_a !== 32'h0BADF00D) begin
                    tests_failed++;
                    $display("FAIL restart_first cycle=%0d coord=%b data=%h exp 12/000000/0badf00d",
                             c, {out_row_a, out_col_a, win_row_a, win_col_a}, out_data_a);
                end
                $display("[TB] restart first out cycle %0d data=%h", c, out_data_a);
            end
            @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL restart_timeout got=no_output exp=output");
        end
        for (c = 0; c < 80 && busy_a; c++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_relu();
        logic [31:0] vals [4];
        logic [31:0] exp_d;
        int nv, c;
        vals[0] = 32'hC0000000; vals[1] = 32'h3F800000;
        vals[2] = 32'h80000000; vals[3] = 32'h7F7FFFFF;
        out_ready_a   = 1'b1;
        unit_result_a = vals[0];
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        nv = 0;
        for (c = 0; c < 120 && nv < 4; c++) begin
            if (out_valid_a) begin
`ifdef CONV_SCHED_RELU_EN
                exp_d = vals[nv][31] ? 32'h0 : vals[nv];
`else
                exp_d = vals[nv];
`endif
                tests_run++;
                if (out_data_a !== exp_d) begin
                    tests_failed++;
                    $display("FAIL relu_data[%0d] in=%h got=%h exp=%h", nv, vals[nv], out_data_a, exp_d);
                end
                $display("[TB] relu out %0d in=%h data=%h", nv, vals[nv], out_data_a);
                nv++;
                if (nv < 4) unit_result_a = vals[nv];
            end
            @(negedge clk);
        end
        tests_run++;
        if (nv != 4) begin
            tests_failed++;
            $display("FAIL relu_count outputs=%0d exp=4", nv);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset = 1'b1;
        start_a = 1'b0; out_ready_a = 1'b1; unit_result_a = '0;
        start_b = 1'b0; out_ready_b = 1'b1; unit_result_b = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_stride();
        test_reset_midrun();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
